// File: rtl/datapath_shl.sv
// Single-bus 32-bit CPU datapath slice: PC, IR, MAR, MDR, Y, 64-bit Z, R1/R3/R5,
// a priority bus mux and an ALU (SHL, IncPC, add). All strobes come from an external sequencer.
module datapath_shl #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             R3out,
    input  logic             R5out,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             R1in,
    input  logic             R3in,
    input  logic             R5in,
    input  logic             IncPC,
    input  logic             SHL,
    input  logic             Read,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] R1_q,
    output logic [WIDTH-1:0] R3_q,
    output logic [WIDTH-1:0] R5_q,
    output logic [WIDTH-1:0] PC_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] MDR_q,
    output logic [WIDTH-1:0] Y_q,
    output logic [WIDTH-1:0] ZHi_q,
    output logic [WIDTH-1:0] ZLo_q
);

    logic [WIDTH-1:0]   r_pc, r_ir, r_mar, r_mdr, r_y, r_zhi, r_zlo;
    logic [WIDTH-1:0]   r_r1, r_r3, r_r5;
    logic [WIDTH-1:0]   w_bus;
    logic [WIDTH-1:0]   w_inc;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_alu;
    logic [WIDTH-1:0]   w_mdr_d;

    // Fixed priority keeps overlapping source selects deterministic.
    always_comb begin
        w_bus = '0;
        if (MDRout)       w_bus = r_mdr;
        else if (Zlowout) w_bus = r_zlo;
        else if (R3out)   w_bus = r_r3;
        else if (R5out)   w_bus = r_r5;
        else if (PCout)   w_bus = r_pc;
    end

    assign w_inc = w_bus + WIDTH'(1);
    assign w_sum = {1'b0, r_y} + {1'b0, w_bus};

    // Shift-out bit and add carry both land in ZHi[0]; IncPC wraps at WIDTH bits.
    always_comb begin
        w_alu = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_alu[WIDTH] = w_sum[WIDTH];
        if (SHL)        w_alu = {{(WIDTH-1){1'b0}}, r_y, 1'b0};
        else if (IncPC) w_alu = {{WIDTH{1'b0}}, w_inc};
    end

    assign w_mdr_d = Read ? Mdatain : w_bus;

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_zhi <= '0;
            r_zlo <= '0;
            r_r1  <= '0;
            r_r3  <= '0;
            r_r5  <= '0;
        end else begin
            if (PCin)  r_pc  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (MDRin) r_mdr <= w_mdr_d;
            if (Yin)   r_y   <= w_bus;
            if (R1in)  r_r1  <= w_bus;
            if (R3in)  r_r3  <= w_bus;
            if (R5in)  r_r5  <= w_bus;
            if (Zin) begin
                r_zlo <= w_alu[WIDTH-1:0];
                r_zhi <= w_alu[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign BusMuxOut = w_bus;
    assign R1_q      = r_r1;
    assign R3_q      = r_r3;
    assign R5_q      = r_r5;
    assign PC_q      = r_pc;
    assign IR_q      = r_ir;
    assign MAR_q     = r_mar;
    assign MDR_q     = r_mdr;
    assign Y_q       = r_y;
    assign ZHi_q     = r_zhi;
    assign ZLo_q     = r_zlo;

endmodule

// File: tb/tb_datapath_shl.sv
// Directed bench for datapath_shl: reset, preload, fetch, SHL, overflow/wrap and bus priority.
module tb_datapath_shl;

    logic        Clock = 1'b0;
    logic        clear;
    logic        PCout, Zlowout, MDRout, R3out, R5out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin;
    logic        R1in, R3in, R5in;
    logic        IncPC, SHL, Read;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut, R1_q, R3_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, ZHi_q, ZLo_q;

    int errors = 0;
    int checks = 0;

    datapath_shl #(.WIDTH(32)) dut (
        .Clock(Clock), .clear(clear),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .R3out(R3out), .R5out(R5out),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .R1in(R1in), .R3in(R3in), .R5in(R5in),
        .IncPC(IncPC), .SHL(SHL), .Read(Read), .Mdatain(Mdatain),
        .BusMuxOut(BusMuxOut), .R1_q(R1_q), .R3_q(R3_q), .R5_q(R5_q), .PC_q(PC_q),
        .IR_q(IR_q), .MAR_q(MAR_q), .MDR_q(MDR_q), .Y_q(Y_q), .ZHi_q(ZHi_q), .ZLo_q(ZLo_q)
    );

    always #5 Clock = ~Clock;

    task automatic idle();
        PCout = 0; Zlowout = 0; MDRout = 0; R3out = 0; R5out = 0;
        MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
        R1in = 0; R3in = 0; R5in = 0; IncPC = 0; SHL = 0; Read = 0;
    endtask

    // Apply the current strobes across one rising edge, then return them to idle.
    task automatic step();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic mem_to_mdr(input logic [31:0] d);
        Mdatain = d; Read = 1; MDRin = 1; step();
    endtask

    task automatic test_reset();
        mem_to_mdr(32'h55);
        MDRout = 1; R3in = 1; step();
        checks++;
        if (R3_q !== 32'h55) begin errors++; $display("FAIL reset_preload R3 got %h want %h", R3_q, 32'h55); end
        #2 clear = 1;
        #1;
        checks++;
        if ({R3_q, MDR_q, PC_q, BusMuxOut} !== '0) begin
            errors++; $display("FAIL reset_async R3=%h MDR=%h PC=%h bus=%h want all 0", R3_q, MDR_q, PC_q, BusMuxOut);
        end
        Mdatain = 32'h77; Read = 1; MDRin = 1; step();
        checks++;
        if (MDR_q !== 32'h0) begin errors++; $display("FAIL reset_beats_load MDR got %h want 0", MDR_q); end
        clear = 0;
        step();
        checks++;
        if ({R1_q, R3_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, ZHi_q, ZLo_q} !== '0) begin
            errors++; $display("FAIL reset_hold R3=%h MDR=%h Z=%h_%h want all 0", R3_q, MDR_q, ZHi_q, ZLo_q);
        end
    endtask

    task automatic test_preload();
        mem_to_mdr(32'h12); MDRout = 1; R3in = 1; step();
        mem_to_mdr(32'h14); MDRout = 1; R5in = 1; step();
        mem_to_mdr(32'h18); MDRout = 1; R1in = 1; step();
        checks++;
        if (R3_q !== 32'h12) begin errors++; $display("FAIL preload_R3 got %h want %h", R3_q, 32'h12); end
        checks++;
        if (R5_q !== 32'h14) begin errors++; $display("FAIL preload_R5 got %h want %h", R5_q, 32'h14); end
        checks++;
        if (R1_q !== 32'h18) begin errors++; $display("FAIL preload_R1 got %h want %h", R1_q, 32'h18); end
        R5out = 1; #1;
        checks++;
        if (BusMuxOut !== 32'h14) begin errors++; $display("FAIL bus_R5 got %h want %h", BusMuxOut, 32'h14); end
        idle();
    endtask

    task automatic test_fetch();
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step();
        checks++;
        if (MAR_q !== 32'h0 || ZLo_q !== 32'h1 || ZHi_q !== 32'h0) begin
            errors++; $display("FAIL fetch_T0 MAR=%h Z=%h_%h want 0 / 0_1", MAR_q, ZHi_q, ZLo_q);
        end
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h28918000; step();
        checks++;
        if (PC_q !== 32'h1 || MDR_q !== 32'h28918000) begin
            errors++; $display("FAIL fetch_T1 PC=%h MDR=%h want 1 / 28918000", PC_q, MDR_q);
        end
        MDRout = 1; IRin = 1; step();
        checks++;
        if (IR_q !== 32'h28918000) begin errors++; $display("FAIL fetch_T2 IR got %h want 28918000", IR_q); end
    endtask

    task automatic test_shl();
        R3out = 1; Yin = 1; step();
        checks++;
        if (Y_q !== 32'h12) begin errors++; $display("FAIL shl_T3 Y got %h want 12", Y_q); end
        SHL = 1; Zin = 1; step();
        checks++;
        if (ZLo_q !== 32'h24 || ZHi_q !== 32'h0) begin
            errors++; $display("FAIL shl_T4 Z got %h_%h want 0_24", ZHi_q, ZLo_q);
        end
        Zlowout = 1; R1in = 1; step();
        checks++;
        if (R1_q !== 32'h24) begin errors++; $display("FAIL shl_T5 R1 got %h want 24", R1_q); end
    endtask

    task automatic test_overflow();
        mem_to_mdr(32'h80000001); MDRout = 1; R3in = 1; step();
        R3out = 1; Yin = 1; step();
        SHL = 1; Zin = 1; step();
        checks++;
        if (ZLo_q !== 32'h2 || ZHi_q !== 32'h1) begin
            errors++; $display("FAIL shl_overflow Z got %h_%h want 1_2", ZHi_q, ZLo_q);
        end
        mem_to_mdr(32'hFFFFFFFF); MDRout = 1; PCin = 1; step();
        PCout = 1; IncPC = 1; Zin = 1; step();
        checks++;
        if (ZLo_q !== 32'h0 || ZHi_q !== 32'h0) begin
            errors++; $display("FAIL incpc_wrap Z got %h_%h want 0_0", ZHi_q, ZLo_q);
        end
        // Y=0x80000001 + MDR=0xFFFFFFFF = 0x1_80000000
        MDRout = 1; Zin = 1; step();
        checks++;
        if (ZLo_q !== 32'h80000000 || ZHi_q !== 32'h1) begin
            errors++; $display("FAIL add_carry Z got %h_%h want 1_80000000", ZHi_q, ZLo_q);
        end
        PCout = 1; PCin = 1; step();
        checks++;
        if (PC_q !== 32'hFFFFFFFF) begin errors++; $display("FAIL self_load PC got %h want ffffffff", PC_q); end
    endtask

    task automatic test_bus_priority();
        mem_to_mdr(32'hB); MDRout = 1; PCin = 1; step();
        mem_to_mdr(32'hA);
        MDRout = 1; PCout = 1; #1;
        checks++;
        if (BusMuxOut !== 32'hA) begin errors++; $display("FAIL prio_mdr_pc bus got %h want a", BusMuxOut); end
        idle(); Zlowout = 1; R3out = 1; #1;
        checks++;
        if (BusMuxOut !== 32'h80000000) begin errors++; $display("FAIL prio_z_r3 bus got %h want 80000000", BusMuxOut); end
        idle(); R3out = 1; PCout = 1; #1;
        checks++;
        if (BusMuxOut !== 32'h80000001) begin errors++; $display("FAIL prio_r3_pc bus got %h want 80000001", BusMuxOut); end
        idle(); #1;
        checks++;
        if (BusMuxOut !== 32'h0) begin errors++; $display("FAIL bus_none got %h want 0", BusMuxOut); end
    endtask

    initial begin
        idle();
        Mdatain = '0;
        clear = 1;
        #12 clear = 0;
        #1;
        checks++;
        if ({R1_q, R3_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q, ZHi_q, ZLo_q, BusMuxOut} !== '0) begin
            errors++; $display("FAIL initial_reset PC=%h MDR=%h Z=%h_%h want all 0", PC_q, MDR_q, ZHi_q, ZLo_q);
        end
        @(negedge Clock);
        test_reset();
        test_preload();
        test_fetch();
        test_shl();
        test_overflow();
        test_bus_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_shl.md
Name: datapath_shl

Overview:
- 32-bit single-bus CPU datapath slice built around one shared bus.
- Registers: PC, IR, MAR, MDR, Y, 64-bit Z (ZHi/ZLo) and general registers R1, R3, R5.
- An ALU sits between Y/bus and Z and supports PC increment, shift-left-by-one and a default add.
- A control-step sequencer outside this block drives all strobes; this block contains no FSM.

Parameters:
- WIDTH, 32, data/bus/register width.

Ports:
- Clock  in  1  system clock; all registers update on its rising edge.
- clear  in  1  asynchronous active-high reset; clears every register.
- PCout, Zlowout, MDRout, R3out, R5out  in  1 each  bus source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin  in  1 each  register load enables.
- R1in, R3in, R5in  in  1 each  general register load enables.
- IncPC  in  1  ALU op: Z = bus + 1.
- SHL  in  1  ALU op: Z = Y << 1.
- Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value (observability).
- R1_q, R3_q, R5_q, PC_q, IR_q, MAR_q, MDR_q, Y_q  out  32 each  register contents.
- ZHi_q, ZLo_q  out  32 each  Z register halves.
- Connection is by name. Clock and reset are fixed as one clock with asynchronous active-high reset.

Behaviour:
- Reset: clear=1 forces all registers to 0 immediately, independent of Clock. Every output therefore reads 0 during reset, including BusMuxOut, since all sources are 0.
- Bus: combinational mux with fixed priority MDRout > Zlowout > R3out > R5out > PCout.
  - Intended use is one-hot; the priority only makes overlap deterministic.
  - No source asserted: bus = 0.
- Register load: on a rising Clock edge, any register whose *in strobe is 1 captures the bus. Exceptions:
  - MDR captures (Read ? Mdatain : bus) when MDRin=1.
  - Z captures the ALU result when Zin=1: ZLo = result[31:0], ZHi = result[63:32].
- Registers whose strobe is 0 hold their value.
- ALU (combinational, 64-bit result), priority SHL > IncPC > add:
  - SHL: result = {31'b0, Y[31], Y[30:0], 1'b0}. Y is shifted left one place and the bit shifted out goes to ZHi[0].
  - IncPC: result = zero-extended (bus + 1). The 32-bit sum wraps, so 0xFFFFFFFF+1 gives ZLo=0 and ZHi=0.
  - Otherwise: result = zero-extended 33-bit (Y + bus); the carry goes to ZHi[0].
- Latency:
  - Each register transfer takes one clock; load strobes and bus sources must be stable before the edge.
  - Z is readable on the bus (Zlowout) from the cycle after Zin.
- Simultaneous load of a register that is also the bus source: the register captures its own old value.
- Reset asserted mid-sequence wins over any load in the same cycle. After reset deasserts, the next rising edge resumes normal loading.
- Instruction fetch step sequence, one clock per step:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- SHL instruction step sequence:
  - T3: R3out, Yin.
  - T4: SHL, Zin.
  - T5: Zlowout, R1in.

Test Plan:
- Reset: load R3=0x55, assert clear between clock edges -> all *_q read 0 at once; after release, registers hold 0.
- Register preload: Mdatain=0x12 with Read+MDRin, then MDRout+R3in -> R3=0x12. Repeat with 0x14 into R5 and 0x18 into R1 -> R5=0x14, R1=0x18.
- Fetch: PC=0, one-hot T0..T2 with Mdatain=0x28918000 -> MAR=0, PC=1, MDR=0x28918000, IR=0x28918000.
- SHL: R3=0x12, then T3/T4/T5 -> Y=0x12, ZLo=0x24, ZHi=0, R1=0x24.
- SHL overflow: R3=0x80000001, SHL -> ZLo=0x00000002, ZHi=0x00000001. IncPC with PC=0xFFFFFFFF -> ZLo=0.
- Bus priority: MDRout and PCout asserted together with MDR=0xA, PC=0xB -> BusMuxOut=0xA. No source asserted -> BusMuxOut=0.
